// File: rtl/cusp_pkg.sv
// -----------------------------------------------------------------------------
// cusp_pkg
// Shared definitions for the cusp shaping filter: default datapath widths,
// the recursion accumulator type, the peak-detector state encoding and the
// output saturation limits for the default output width.
// -----------------------------------------------------------------------------
package cusp_pkg;

   localparam int SIZE_ACC_DEF = 40;
   localparam int SIZE_OUT_DEF = 16;

   // Accumulator type for the dk, dl, p, q and s recursions.
   typedef logic signed [SIZE_ACC_DEF-1:0] acc_t;

   // Peak detector states.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ABOVE = 1'b1
   } peak_state_t;

   // Saturation limits of a signed SIZE_OUT_DEF-bit output.
   localparam logic signed [SIZE_OUT_DEF-1:0] SAT_MAX = {1'b0, {(SIZE_OUT_DEF-1){1'b1}}};
   localparam logic signed [SIZE_OUT_DEF-1:0] SAT_MIN = {1'b1, {(SIZE_OUT_DEF-1){1'b0}}};

endpackage

// File: rtl/cusp_filter_pipe_delay_line.sv
// -----------------------------------------------------------------------------
// cusp_delay_line
// Sample shift register holding the last K accepted samples. It shifts only
// when en=1, so gaps in the input stream do not age the stored history.
// mem[0] holds v(n-1) relative to the sample currently on din.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high clear of all stored samples
//   en      in   shift din into the line this cycle
//   din     in   SIZE_IN  newest sample v(n), signed
//   tap_k   out  SIZE_IN  v(n-K)
//   tap_l   out  SIZE_IN  v(n-L)
//   tap_l1  out  SIZE_IN  v(n-L-1)
// -----------------------------------------------------------------------------
module cusp_delay_line #(
   parameter int SIZE_IN = 14,
   parameter int K       = 11,
   parameter int L       = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic signed [SIZE_IN-1:0]  din,
   output logic signed [SIZE_IN-1:0]  tap_k,
   output logic signed [SIZE_IN-1:0]  tap_l,
   output logic signed [SIZE_IN-1:0]  tap_l1
);

   logic signed [SIZE_IN-1:0] mem_r [0:K-1];

   // Shift register: clear on reset, shift one place per accepted sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < K; i++) begin
            mem_r[i] <= {SIZE_IN{1'b0}};
         end
      end else if (en) begin
         mem_r[0] <= din;
         for (int i = 1; i < K; i++) begin
            mem_r[i] <= mem_r[i-1];
         end
      end
   end

   // Taps are taken before the shift, i.e. relative to the sample on din.
   assign tap_k  = mem_r[K-1];
   assign tap_l  = mem_r[L-1];
   assign tap_l1 = mem_r[L];

endmodule

// File: rtl/cusp_filter_pipe.sv
// -----------------------------------------------------------------------------
// cusp_filter_pipe
// Pipelined cusp-like shaping filter with generic L, K, M1, M2. Five registered
// stages: S1 dk and K*dl, S2 p, S3 q and M1*p, S4 s, S5 shift/saturate/output.
// A sample accepted in cycle c appears on out_data with out_valid in cycle c+5.
// Each stage only updates its recursion when its valid bit is set, so input
// gaps do not advance the recursions.
//
// Optional feature: define CUSP_PEAK_DETECT_EN to build the threshold peak
// detector. Without it peak_valid/peak_data are tied to zero and thresh is
// ignored; the port list is identical in both builds.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   in_valid    in   in_data holds a new sample
//   in_data     in   SIZE_IN   signed input sample
//   thresh      in   SIZE_OUT  signed peak threshold
//   out_valid   out  out_data holds a new result
//   out_data    out  SIZE_OUT  signed filter output
//   sat_flag    out  sticky saturation indicator, cleared only by reset
//   peak_valid  out  one-cycle strobe, peak_data valid
//   peak_data   out  SIZE_OUT  maximum output of the last pulse above thresh
// -----------------------------------------------------------------------------
module cusp_filter_pipe
   import cusp_pkg::*;
#(
   parameter int SIZE_IN  = 14,
   parameter int SIZE_OUT = SIZE_OUT_DEF,
   parameter int SIZE_ACC = SIZE_ACC_DEF,
   parameter int L        = 5,
   parameter int K        = 11,
   parameter int M1       = 16,
   parameter int M2       = 1,
   parameter int SHIFT    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic signed [SIZE_IN-1:0]  in_data,
   input  logic signed [SIZE_OUT-1:0] thresh,
   output logic                       out_valid,
   output logic signed [SIZE_OUT-1:0] out_data,
   output logic                       sat_flag,
   output logic                       peak_valid,
   output logic signed [SIZE_OUT-1:0] peak_data
);

   localparam logic signed [SIZE_ACC-1:0] ACC_ZERO = {SIZE_ACC{1'b0}};
   localparam logic signed [SIZE_ACC-1:0] K_ACC    = SIZE_ACC'(K);
   localparam logic signed [SIZE_ACC-1:0] M1_ACC   = SIZE_ACC'(M1);
   localparam logic signed [SIZE_ACC-1:0] M2_ACC   = SIZE_ACC'(M2);
   // Output clamp limits expressed at accumulator width.
   localparam logic signed [SIZE_ACC-1:0] ACC_HI =
      {{(SIZE_ACC-SIZE_OUT+1){1'b0}}, {(SIZE_OUT-1){1'b1}}};
   localparam logic signed [SIZE_ACC-1:0] ACC_LO =
      {{(SIZE_ACC-SIZE_OUT+1){1'b1}}, {(SIZE_OUT-1){1'b0}}};

   logic signed [SIZE_IN-1:0]  tap_k_s;
   logic signed [SIZE_IN-1:0]  tap_l_s;
   logic signed [SIZE_IN-1:0]  tap_l1_s;
   logic signed [SIZE_ACC-1:0] dk_s;
   logic signed [SIZE_ACC-1:0] dl_s;
   logic signed [SIZE_ACC-1:0] kdl_s;
   logic signed [SIZE_ACC-1:0] sh_s;
   logic signed [SIZE_OUT-1:0] y_s;
   logic                       clamp_s;

   logic signed [SIZE_ACC-1:0] dk_r;
   logic signed [SIZE_ACC-1:0] kdl_r;
   logic signed [SIZE_ACC-1:0] p_r;
   logic signed [SIZE_ACC-1:0] q_r;
   logic signed [SIZE_ACC-1:0] m1p_r;
   logic signed [SIZE_ACC-1:0] s_r;
   logic                       vld1_r;
   logic                       vld2_r;
   logic                       vld3_r;
   logic                       vld4_r;
   logic                       out_valid_r;
   logic signed [SIZE_OUT-1:0] out_data_r;
   logic                       sat_flag_r;

   cusp_delay_line #(
      .SIZE_IN (SIZE_IN),
      .K       (K),
      .L       (L)
   ) u_delay (
      .clk    (clk),
      .reset  (reset),
      .en     (in_valid),
      .din    (in_data),
      .tap_k  (tap_k_s),
      .tap_l  (tap_l_s),
      .tap_l1 (tap_l1_s)
   );

   // S1 operands: differences sign-extended to accumulator width.
   always_comb begin
      dk_s  = SIZE_ACC'(in_data) - SIZE_ACC'(tap_k_s);
      dl_s  = SIZE_ACC'(tap_l_s) - SIZE_ACC'(tap_l1_s);
      kdl_s = dl_s * K_ACC;
   end

   // S1..S4 pipeline: recursions advance only when their stage holds a sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         dk_r   <= ACC_ZERO;
         kdl_r  <= ACC_ZERO;
         p_r    <= ACC_ZERO;
         q_r    <= ACC_ZERO;
         m1p_r  <= ACC_ZERO;
         s_r    <= ACC_ZERO;
         vld1_r <= 1'b0;
         vld2_r <= 1'b0;
         vld3_r <= 1'b0;
         vld4_r <= 1'b0;
      end else begin
         vld1_r <= in_valid;
         vld2_r <= vld1_r;
         vld3_r <= vld2_r;
         vld4_r <= vld3_r;
         if (in_valid) begin
            dk_r  <= dk_s;
            kdl_r <= kdl_s;
         end
         if (vld1_r) begin
            p_r <= p_r + dk_r - kdl_r;
         end
         if (vld2_r) begin
            q_r   <= q_r + (p_r * M2_ACC);
            m1p_r <= p_r * M1_ACC;
         end
         if (vld3_r) begin
            s_r <= s_r + q_r + m1p_r;
         end
      end
   end

   // S5 operand: arithmetic shift of s, then clamp to the output range.
   always_comb begin
      sh_s    = s_r >>> SHIFT;
      y_s     = sh_s[SIZE_OUT-1:0];
      clamp_s = 1'b0;
      if (sh_s > ACC_HI) begin
         y_s     = ACC_HI[SIZE_OUT-1:0];
         clamp_s = 1'b1;
      end else if (sh_s < ACC_LO) begin
         y_s     = ACC_LO[SIZE_OUT-1:0];
         clamp_s = 1'b1;
      end else begin
         y_s     = sh_s[SIZE_OUT-1:0];
         clamp_s = 1'b0;
      end
   end

   // S5 output register; out_data holds its last value between results.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {SIZE_OUT{1'b0}};
         sat_flag_r  <= 1'b0;
      end else begin
         out_valid_r <= vld4_r;
         if (vld4_r) begin
            out_data_r <= y_s;
         end
         sat_flag_r <= sat_flag_r | (vld4_r & clamp_s);
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign sat_flag  = sat_flag_r;

`ifdef CUSP_PEAK_DETECT_EN
   peak_state_t                state_r;
   peak_state_t                state_next_s;
   logic signed [SIZE_OUT-1:0] max_r;
   logic signed [SIZE_OUT-1:0] max_next_s;
   logic                       peak_valid_r;
   logic                       peak_valid_next_s;
   logic signed [SIZE_OUT-1:0] peak_data_r;
   logic signed [SIZE_OUT-1:0] peak_data_next_s;

   // Peak FSM next state: watches the registered output stream.
   always_comb begin
      state_next_s      = state_r;
      max_next_s        = max_r;
      peak_valid_next_s = 1'b0;
      peak_data_next_s  = peak_data_r;
      case (state_r)
         IDLE: begin
            if (out_valid_r && (out_data_r > thresh)) begin
               state_next_s = ABOVE;
               max_next_s   = out_data_r;
            end else begin
               state_next_s = IDLE;
            end
         end
         ABOVE: begin
            if (out_valid_r) begin
               if (out_data_r > thresh) begin
                  state_next_s = ABOVE;
                  if (out_data_r > max_r) begin
                     max_next_s = out_data_r;
                  end else begin
                     max_next_s = max_r;
                  end
               end else begin
                  // Pulse ends: report the maximum seen while above.
                  state_next_s      = IDLE;
                  peak_valid_next_s = 1'b1;
                  peak_data_next_s  = max_r;
               end
            end else begin
               state_next_s = ABOVE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Peak FSM registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         max_r        <= {SIZE_OUT{1'b0}};
         peak_valid_r <= 1'b0;
         peak_data_r  <= {SIZE_OUT{1'b0}};
      end else begin
         state_r      <= state_next_s;
         max_r        <= max_next_s;
         peak_valid_r <= peak_valid_next_s;
         peak_data_r  <= peak_data_next_s;
      end
   end

   assign peak_valid = peak_valid_r;
   assign peak_data  = peak_data_r;
`else
   logic unused_thresh_s;

   assign unused_thresh_s = ^thresh;
   assign peak_valid      = 1'b0;
   assign peak_data       = {SIZE_OUT{1'b0}};
`endif

endmodule

// File: tb/tb_cusp_filter_pipe.sv
// -----------------------------------------------------------------------------
// tb_cusp_filter_pipe
// Two filter instances (SHIFT=0 and SHIFT=4) share one input stream. A model
// computes p in closed form (windowed sum of the last K samples minus K*v(n-L)),
// accumulates q and s, and predicts every output cycle by cycle.
// -----------------------------------------------------------------------------
module tb_cusp_filter_pipe;

   localparam int K  = 11;
   localparam int L  = 5;
   localparam int M1 = 16;
   localparam int M2 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset;
   logic                in_valid;
   logic signed [13:0]  in_data;
   logic signed [15:0]  thresh;
   logic                ov  [2];
   logic signed [15:0]  od  [2];
   logic                sf  [2];
   logic                pv  [2];
   logic signed [15:0]  pd  [2];

   cusp_filter_pipe #(.SHIFT(0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .thresh(thresh), .out_valid(ov[0]), .out_data(od[0]), .sat_flag(sf[0]),
      .peak_valid(pv[0]), .peak_data(pd[0])
   );

   cusp_filter_pipe #(.SHIFT(4)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .thresh(thresh), .out_valid(ov[1]), .out_data(od[1]), .sat_flag(sf[1]),
      .peak_valid(pv[1]), .peak_data(pd[1])
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int first_cyc = 0;

   typedef struct {
      int     due;
      longint s;
   } exp_t;

   exp_t   exp_q[$];
   longint hist[$];
   longint p_m, q_m, s_m;
   int     last_y  [2];
   bit     sat_m   [2];
   bit     above_m [2];
   int     max_m   [2];
   int     pk_due  [2];
   int     pk_exp  [2];
   int     pk_last [2];
   int     log0[$];
   int     logc0[$];
   int     log1[$];
   int     model_log0[$];
   int     peak_log0[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic longint wrap40(input longint x);
      logic signed [39:0] t;
      t = x[39:0];
      return longint'(t);
   endfunction

   function automatic int sat16(input longint x, output bit clipped);
      clipped = 1'b1;
      if (x > 64'sd32767) return 32767;
      if (x < -64'sd32768) return -32768;
      clipped = 1'b0;
      return int'(x);
   endfunction

   function automatic longint vat(input int j);
      if (j < hist.size()) return hist[hist.size()-1-j];
      return 64'sd0;
   endfunction

   function automatic int qat(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -999999;
   endfunction

   // Model: accept samples on the rising edge, schedule outputs 4 edges later.
   always @(posedge clk) begin
      longint win;
      cyc = cyc + 1;
      if (reset) begin
         hist.delete();
         exp_q.delete();
         p_m = 0; q_m = 0; s_m = 0;
         for (int d = 0; d < 2; d++) begin
            last_y[d] = 0; sat_m[d] = 1'b0; above_m[d] = 1'b0;
            max_m[d] = 0; pk_due[d] = -1; pk_exp[d] = 0; pk_last[d] = 0;
         end
      end else if (in_valid) begin
         hist.push_back(longint'(in_data));
         if (hist.size() > K + 1) void'(hist.pop_front());
         win = 0;
         for (int j = 0; j < K; j++) win += vat(j);
         p_m = wrap40(win - longint'(K) * vat(L));
         q_m = wrap40(q_m + longint'(M2) * p_m);
         s_m = wrap40(s_m + q_m + longint'(M1) * p_m);
         exp_q.push_back('{cyc + 4, s_m});
      end
   end

   // Compare: every cycle, away from the rising edge.
   always @(negedge clk) begin
      bit     due;
      bit     c;
      longint sv;
      int     y;
      due = 1'b0;
      sv  = 0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         due = 1'b1;
         sv  = exp_q[0].s;
         void'(exp_q.pop_front());
      end
      for (int d = 0; d < 2; d++) begin
         if (due) begin
            y = sat16(sv >>> ((d == 0) ? 0 : 4), c);
            last_y[d] = y;
            if (c) sat_m[d] = 1'b1;
            if (d == 0) model_log0.push_back(y);
`ifdef CUSP_PEAK_DETECT_EN
            if (!above_m[d]) begin
               if (y > int'(thresh)) begin
                  above_m[d] = 1'b1;
                  max_m[d]   = y;
               end
            end else if (y > int'(thresh)) begin
               if (y > max_m[d]) max_m[d] = y;
            end else begin
               above_m[d] = 1'b0;
               pk_due[d]  = cyc + 1;
               pk_exp[d]  = max_m[d];
            end
`endif
         end
         chk("out_valid", longint'(ov[d]), longint'(due));
         chk("out_data", longint'(od[d]), longint'(last_y[d]));
         chk("sat_flag", longint'(sf[d]), longint'(sat_m[d]));
         if (pk_due[d] == cyc) pk_last[d] = pk_exp[d];
         chk("peak_valid", longint'(pv[d]), longint'(pk_due[d] == cyc));
         chk("peak_data", longint'(pd[d]), longint'(pk_last[d]));
      end
      if (ov[0]) begin
         log0.push_back(int'(od[0]));
         logc0.push_back(cyc);
      end
      if (ov[1]) log1.push_back(int'(od[1]));
      if (pv[0]) peak_log0.push_back(int'(pd[0]));
   end

   task automatic drive(input bit r, input bit v, input int d);
      @(posedge clk);
      #1;
      reset    = r;
      in_valid = v;
      in_data  = 14'(d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 0);
      drive(1'b0, 1'b0, 0);
   endtask

   task automatic clear_logs();
      log0.delete(); logc0.delete(); log1.delete();
      model_log0.delete(); peak_log0.delete();
   endtask

   task automatic step(input int amp, input int n, input bit alt);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, alt ? (i % 2 == 0) : 1'b1, amp);
         if (i == 0) first_cyc = cyc;
      end
   endtask

   initial begin
      int lit [11];
      int ref1[$];
      lit = '{17, 52, 106, 180, 275, 205, 147, 102, 71, 55, 55};
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 14'sd0;
      thresh   = 16'sd100;
      repeat (3) drive(1'b1, 1'b0, 0);
      idle(2);

      // Unit step, SHIFT=0 instance against hand-computed values.
      clear_logs();
      step(1, 25, 1'b0);
      idle(8);
      chk("step_count", log0.size(), 25);
      for (int i = 0; i < 11; i++) begin
         chk("step_lit", qat(log0, i), lit[i]);
         chk("model_lit", qat(model_log0, i), lit[i]);
      end
      chk("step_tail", qat(log0, 24), 55);
      chk("step_latency", qat(logc0, 0) - first_cyc, 5);

      // Amplitude 100, SHIFT=4 instance settles at 5500>>>4.
      do_reset();
      clear_logs();
      step(100, 40, 1'b0);
      idle(8);
      chk("amp100_count", log1.size(), 40);
      chk("amp100_settle", qat(log1, 39), 343);
      chk("amp100_peak", qat(log1, 4), 1718);
      chk("amp100_nosat", longint'(sf[1]), 0);
      ref1 = log1;

      // Same step with in_valid on alternate cycles.
      do_reset();
      clear_logs();
      step(100, 80, 1'b1);
      idle(8);
      chk("alt_count", log1.size(), 40);
      for (int i = 0; i < 40; i++) chk("alt_seq", qat(log1, i), qat(ref1, i));

      // Reset mid-step, then resume.
      do_reset();
      step(1, 7, 1'b0);
      drive(1'b1, 1'b1, 1);
      drive(1'b0, 1'b0, 0);
      clear_logs();
      step(1, 12, 1'b0);
      idle(8);
      chk("resume_latency", qat(logc0, 0) - first_cyc, 5);
      chk("resume_first", qat(log0, 0), 17);
      chk("resume_count", log0.size(), 12);

      // Large step saturates; flag is sticky until reset.
      do_reset();
      clear_logs();
      step(8191, 30, 1'b0);
      idle(8);
      chk("sat_value", qat(log0, 29), 32767);
      chk("sat_flag_set", longint'(sf[0]), 1);
      idle(5);
      chk("sat_flag_sticky", longint'(sf[0]), 1);
      do_reset();
      chk("sat_flag_clear", longint'(sf[0]), 0);

      // Unit pulses against thresh=100.
      clear_logs();
      thresh = 16'sd100;
      repeat (2) begin
         step(1, 30, 1'b0);
         step(0, 30, 1'b0);
      end
      idle(8);
`ifdef CUSP_PEAK_DETECT_EN
      chk("peak_count", peak_log0.size(), 2);
      chk("peak_first", qat(peak_log0, 0), 275);
`else
      chk("peak_absent", peak_log0.size(), 0);
`endif

      // Randomized traffic with occasional resets and threshold changes.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if (i % 300 == 0) thresh = 16'($urandom_range(0, 4000) - 1000);
         drive($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 7,
               int'($urandom_range(0, 16383)) - 8192);
      end
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
